// File: rtl/bcd_operand_loader_if.sv
// Operand-entry bus between the DE2 switch/key front end and the BCD operand loader.
interface bcd_operand_loader_if;
  logic [3:0] DigitIn;
  logic       CinIn;
  logic       KeyLoad_n;
  logic       KeyClear_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       Valid;
  logic       DigitErr;
  logic [1:0] State;

  // Board side: drives switches and keys, observes latched operands.
  modport master (
    output DigitIn, CinIn, KeyLoad_n, KeyClear_n,
    input  A, B, Cin, Valid, DigitErr, State
  );

  // Loader side.
  modport slave (
    input  DigitIn, CinIn, KeyLoad_n, KeyClear_n,
    output A, B, Cin, Valid, DigitErr, State
  );
endinterface

// File: rtl/bcd_operand_loader.sv
// Captures BCD operand A, then B plus carry-in, on debounced load-key presses and
// holds them stable for the downstream one-digit BCD adder and HEX display.
module bcd_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                 CLOCK_50,
  input logic                 Reset,
  bcd_operand_loader_if.slave bus
);

  localparam int unsigned DIGIT_W = 4;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    READY = 2'b10
  } state_t;

  logic               load_meta, load_sync;
  logic               clr_meta, clr_sync;
  logic [DIGIT_W-1:0] dig_meta, dig_sync;
  logic               cin_meta, cin_sync;

  logic [CNT_W-1:0]   cnt_q;
  logic               deb_q;
  logic               press_q;

  state_t             state_q, state_n;
  logic [DIGIT_W-1:0] a_q, a_n, b_q, b_n;
  logic               cin_q, cin_n, valid_q, valid_n, err_q, err_n;

  logic               clear_c;

  // Clear acts exactly like reset for the debouncer and the operand registers.
  assign clear_c = Reset | ~clr_sync;

  // Two-flop synchronisers for all asynchronous board inputs.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      load_meta <= 1'b1;
      load_sync <= 1'b1;
      clr_meta  <= 1'b1;
      clr_sync  <= 1'b1;
      dig_meta  <= '0;
      dig_sync  <= '0;
      cin_meta  <= 1'b0;
      cin_sync  <= 1'b0;
    end else begin
      load_meta <= bus.KeyLoad_n;
      load_sync <= load_meta;
      clr_meta  <= bus.KeyClear_n;
      clr_sync  <= clr_meta;
      dig_meta  <= bus.DigitIn;
      dig_sync  <= dig_meta;
      cin_meta  <= bus.CinIn;
      cin_sync  <= cin_meta;
    end
  end

  // Load-key debouncer; press_q pulses for one cycle on a qualified 1->0 transition.
  always_ff @(posedge CLOCK_50) begin
    if (clear_c) begin
      cnt_q   <= '0;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (load_sync == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        deb_q   <= load_sync;
        press_q <= deb_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Entry FSM state and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (clear_c) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      cin_q   <= cin_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  // Next-state and next-output logic, only advanced by a debounced press.
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    cin_n   = cin_q;
    valid_n = valid_q;
    err_n   = err_q;
    case (state_q)
      GET_A: begin
        if (press_q) begin
          if (dig_sync <= DIGIT_MAX) begin
            a_n     = dig_sync;
            err_n   = 1'b0;
            state_n = GET_B;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      GET_B: begin
        if (press_q) begin
          if (dig_sync <= DIGIT_MAX) begin
            b_n     = dig_sync;
            cin_n   = cin_sync;
            err_n   = 1'b0;
            valid_n = 1'b1;
            state_n = READY;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      READY: begin
        if (press_q) begin
          a_n     = '0;
          b_n     = '0;
          cin_n   = 1'b0;
          valid_n = 1'b0;
          state_n = GET_A;
        end
      end
      default: begin
        state_n = GET_A;
        a_n     = '0;
        b_n     = '0;
        cin_n   = 1'b0;
        valid_n = 1'b0;
        err_n   = 1'b0;
      end
    endcase
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.Cin      = cin_q;
  assign bus.Valid    = valid_q;
  assign bus.DigitErr = err_q;
  assign bus.State    = 2'(state_q);

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Self-checking bench for bcd_operand_loader with a short debounce window.
module tb_bcd_operand_loader;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bcd_operand_loader_if bus();

  bcd_operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLOCK_50(clk),
    .Reset   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] digit;
    logic       cin;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin_e;
    logic       valid;
    logic       err;
    logic [1:0] state;
  } vec_t;

  vec_t vecs[12];

  // Reference model state, evolved from the entry rules with plain arithmetic.
  int m_a, m_b, m_cin, m_valid, m_err, m_phase;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int a, input int b, input int c,
                           input int v, input int e, input int s);
    check({tag, ".A"}, int'(bus.A), a);
    check({tag, ".B"}, int'(bus.B), b);
    check({tag, ".Cin"}, int'(bus.Cin), c);
    check({tag, ".Valid"}, int'(bus.Valid), v);
    check({tag, ".DigitErr"}, int'(bus.DigitErr), e);
    check({tag, ".State"}, int'(bus.State), s);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.KeyLoad_n  = 1'b1;
    bus.KeyClear_n = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(4);
  endtask

  // Clean press: digit set up first, key held low then released long enough to re-qualify.
  task automatic do_press(input logic [3:0] d, input logic c, input int low_n, input int high_n);
    bus.DigitIn = d;
    bus.CinIn   = c;
    cycles(4);
    bus.KeyLoad_n = 1'b0;
    cycles(low_n);
    bus.KeyLoad_n = 1'b1;
    cycles(high_n);
  endtask

  task automatic model_press(input int d, input int c);
    case (m_phase)
      0: if (d <= 9) begin m_a = d; m_err = 0; m_phase = 1; end else m_err = 1;
      1: if (d <= 9) begin m_b = d; m_cin = c; m_err = 0; m_valid = 1; m_phase = 2; end
         else m_err = 1;
      default: begin m_a = 0; m_b = 0; m_cin = 0; m_valid = 0; m_phase = 0; end
    endcase
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_cin = 0; m_valid = 0; m_err = 0; m_phase = 0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.DigitIn    = 4'd0;
    bus.CinIn      = 1'b0;
    bus.KeyLoad_n  = 1'b1;
    bus.KeyClear_n = 1'b1;

    //               digit  cin    A      B      Cin    Valid  Err    State
    vecs[0]  = '{4'd3,  1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[1]  = '{4'd8,  1'b1, 4'd3, 4'd8, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[2]  = '{4'd5,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{4'd12, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[4]  = '{4'd5,  1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[5]  = '{4'd15, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[6]  = '{4'd9,  1'b1, 4'd5, 4'd9, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[7]  = '{4'd0,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{4'd9,  1'b0, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[9]  = '{4'd9,  1'b1, 4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[10] = '{4'd10, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{4'd10, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd0};

    // Reset state, checked while Reset is still asserted and after release.
    cycles(2);
    check_all("reset_held", 0, 0, 0, 0, 0, 0);
    do_reset();
    check_all("reset", 0, 0, 0, 0, 0, 0);

    // Vector table: entry, rejection, READY restart.
    foreach (vecs[i]) begin
      do_press(vecs[i].digit, vecs[i].cin, 12, 12);
      check_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin_e,
                vecs[i].valid, vecs[i].err, vecs[i].state);
    end

    // Bounce: 2-cycle toggles never qualify; the final hold acts on the 7th edge.
    do_reset();
    bus.DigitIn = 4'd6;
    bus.CinIn   = 1'b0;
    cycles(4);
    for (int i = 0; i < 5; i++) begin
      bus.KeyLoad_n = 1'b0;
      cycles(2);
      bus.KeyLoad_n = 1'b1;
      cycles(2);
    end
    check("bounce.no_press_state", int'(bus.State), 0);
    check("bounce.no_press_A", int'(bus.A), 0);
    bus.KeyLoad_n = 1'b0;
    cycles(6);
    check("bounce.edge6_state", int'(bus.State), 0);
    cycles(1);
    check("bounce.edge7_state", int'(bus.State), 1);
    check("bounce.edge7_A", int'(bus.A), 6);
    cycles(20);
    check("bounce.held_state", int'(bus.State), 1);
    bus.KeyLoad_n = 1'b1;
    cycles(12);
    check_all("bounce.release", 6, 0, 0, 0, 0, 1);

    // Clear coincident with the internal press pulse in GET_B.
    do_reset();
    do_press(4'd7, 1'b0, 12, 12);
    check_all("clr.setup", 7, 0, 0, 0, 0, 1);
    bus.DigitIn = 4'd4;
    bus.CinIn   = 1'b1;
    cycles(4);
    bus.KeyLoad_n = 1'b0;
    cycles(4);
    bus.KeyClear_n = 1'b0;
    cycles(3);
    check_all("clr.coincident", 0, 0, 0, 0, 0, 0);
    bus.KeyLoad_n = 1'b1;
    cycles(10);
    bus.KeyClear_n = 1'b1;
    cycles(12);
    check_all("clr.after", 0, 0, 0, 0, 0, 0);

    // Reset mid-debounce: the count restarts and needs full re-qualification.
    do_reset();
    bus.DigitIn = 4'd2;
    bus.CinIn   = 1'b0;
    cycles(4);
    bus.KeyLoad_n = 1'b0;
    cycles(4);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    check("rstmid.during", int'(bus.State), 0);
    cycles(6);
    check("rstmid.edge6_state", int'(bus.State), 0);
    check("rstmid.edge6_A", int'(bus.A), 0);
    cycles(1);
    check("rstmid.edge7_state", int'(bus.State), 1);
    check("rstmid.edge7_A", int'(bus.A), 2);
    bus.KeyLoad_n = 1'b1;
    cycles(12);

    // Randomised presses and clears against the reference model.
    do_reset();
    model_clear();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.KeyClear_n = 1'b0;
        cycles(4);
        bus.KeyClear_n = 1'b1;
        cycles(4);
        model_clear();
      end else begin
        int d;
        int c;
        d = int'($urandom_range(0, 15));
        c = int'($urandom_range(0, 1));
        do_press(4'(d), 1'(c), int'($urandom_range(8, 15)), int'($urandom_range(8, 15)));
        model_press(d, c);
      end
      check_all($sformatf("rnd%0d", n), m_a, m_b, m_cin, m_valid, m_err, m_phase);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
